// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and defaults for the memory port arbiter
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  // DM has priority unless IF has already waited through the allowed number of DM grants.
  function automatic logic pick_dm(input logic if_req, input logic dm_req, input logic if_starved);
    return dm_req && !(if_req && if_starved);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between IF and DM
// One transaction at a time: IDLE grants, BUSY waits for done, RESP pulses the ack.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_done_i,
  output logic              grant_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             if_starved;
  logic             win_dm;
  logic             any_req;

  always_comb begin
    if_starved = (starve_cnt == CNT_MAX);
    win_dm     = pick_dm(if_req_i, dm_req_i, if_starved);
    any_req    = if_req_i | dm_req_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      grant_o     <= GNT_IF;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if_ack_o <= 1'b0;
          dm_ack_o <= 1'b0;
          if (start_i && any_req) begin
            state    <= BUSY;
            busy_o   <= 1'b1;
            mem_en_o <= 1'b1;
            grant_o  <= win_dm ? GNT_DM : GNT_IF;
            if (win_dm) begin
              mem_addr_o  <= dm_addr_i;
              mem_we_o    <= dm_we_i;
              mem_wdata_o <= dm_wdata_i;
              // Only DM wins that leave IF waiting count toward forcing an IF grant.
              if (!if_req_i)
                starve_cnt <= '0;
              else if (!if_starved)
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
              mem_addr_o <= if_addr_i;
              mem_we_o   <= 1'b0;
              starve_cnt <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_done_i) begin
            state    <= RESP;
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            if (grant_o == GNT_IF) begin
              if_rdata_o <= mem_rdata_i;
              if_ack_o   <= 1'b1;
            end else begin
              if (!mem_we_o)
                dm_rdata_o <= mem_rdata_i;
              dm_ack_o <= 1'b1;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          busy_o   <= 1'b0;
          if_ack_o <= 1'b0;
          dm_ack_o <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_o   <= 1'b0;
          mem_en_o <= 1'b0;
          mem_we_o <= 1'b0;
          if_ack_o <= 1'b0;
          dm_ack_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Directed vector table, hand-written corner sequences, then random traffic against a reference model.
module tb_mem_port_arbiter;
  import cpu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          grant;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_done_i(mem_done), .grant_o(grant), .busy_o(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctrl();
    return {if_ack, dm_ack, mem_en, mem_we, busy, grant};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0; mem_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic          start, ifr;
    logic [31:0]   ifa;
    logic          dmr, dmwe;
    logic [31:0]   dma, dmwd;
    logic          done;
    logic [31:0]   rd;
    logic [5:0]    ectrl;
    logic [31:0]   eaddr, ewdata, eifrd, edmrd;
  } vec_t;

  vec_t tbl[13];

  // reference model state
  bit            m_busy, m_resp, m_dm, m_we, m_grant;
  logic [31:0]   m_addr, m_wdata, m_ifrd, m_dmrd;
  int            m_starve;
  int            dm_run;

  task automatic model_clear();
    m_busy = 0; m_resp = 0; m_dm = 0; m_we = 0; m_grant = 0;
    m_addr = '0; m_wdata = '0; m_ifrd = '0; m_dmrd = '0;
    m_starve = 0; dm_run = 0;
  endtask

  // Applies the arbitration rules to the inputs present at the coming edge, then checks outputs.
  task automatic model_cycle();
    if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      if (mem_done) begin
        if (!m_dm) m_ifrd = mem_rdata;
        else if (!m_we) m_dmrd = mem_rdata;
        m_busy = 0;
        m_resp = 1;
      end
    end else if (start && (if_req || dm_req)) begin
      m_dm = dm_req && !(if_req && m_starve == SM);
      m_grant = m_dm;
      if (m_dm) begin
        m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
        m_starve = if_req ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
        dm_run = if_req ? dm_run + 1 : 0;
      end else begin
        m_addr = if_addr; m_we = 0; m_starve = 0; dm_run = 0;
      end
      m_busy = 1;
    end
    tick();
    chk("rnd_ctrl", {58'd0, ctrl()},
        {58'd0, m_resp && !m_dm, m_resp && m_dm, m_busy, m_busy && m_we, m_busy || m_resp, m_grant});
    chk("rnd_addr", {32'd0, mem_addr}, {32'd0, m_addr});
    chk("rnd_wdata", {32'd0, mem_wdata}, {32'd0, m_wdata});
    chk("rnd_if_rdata", {32'd0, if_rdata}, {32'd0, m_ifrd});
    chk("rnd_dm_rdata", {32'd0, dm_rdata}, {32'd0, m_dmrd});
    if (dm_run > SM) begin
      chk("rnd_starve_bound", 64'(dm_run), 64'(SM));
      dm_run = SM;
    end
  endtask

  logic [1:0] gseq[$];
  int         exp_g;

  initial begin
    rst = 1'b1;
    idle_inputs();

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("reset_ctrl", {58'd0, ctrl()}, 64'd0);
    chk("reset_addr", {32'd0, mem_addr}, 64'd0);
    chk("reset_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("reset_rdata", {if_rdata, dm_rdata}, 64'd0);
    rst = 1'b0;

    // ---------------- vector table ----------------
    // ctrl bits: {if_ack, dm_ack, mem_en, mem_we, busy, grant}
    tbl[0]  = '{1, 1, 32'h10, 0, 0, 0, 0, 0, 0, 6'b001010, 32'h10, 0, 0, 0};
    tbl[1]  = '{1, 1, 32'h10, 0, 0, 0, 0, 0, 0, 6'b001010, 32'h10, 0, 0, 0};
    tbl[2]  = '{1, 1, 32'h10, 0, 0, 0, 0, 1, 32'hDEADBEEF, 6'b100010, 32'h10, 0, 32'hDEADBEEF, 0};
    tbl[3]  = '{1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h10, 0, 32'hDEADBEEF, 0};
    tbl[4]  = '{1, 0, 0, 1, 1, 32'h40, 32'h1234, 0, 0, 6'b001111, 32'h40, 32'h1234, 32'hDEADBEEF, 0};
    tbl[5]  = '{1, 0, 0, 1, 1, 32'h40, 32'h1234, 0, 0, 6'b001111, 32'h40, 32'h1234, 32'hDEADBEEF, 0};
    tbl[6]  = '{1, 0, 0, 1, 1, 32'h40, 32'h1234, 1, 32'h5555, 6'b010011, 32'h40, 32'h1234, 32'hDEADBEEF, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 32'h40, 32'h1234, 32'hDEADBEEF, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF, 6'b000001, 32'h40, 32'h1234, 32'hDEADBEEF, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 32'h40, 32'h1234, 32'hDEADBEEF, 0};
    tbl[10] = '{1, 0, 0, 1, 0, 32'h80, 32'hAAAA, 0, 0, 6'b001011, 32'h80, 32'hAAAA, 32'hDEADBEEF, 0};
    tbl[11] = '{1, 0, 0, 1, 0, 32'h80, 32'hAAAA, 1, 32'hCAFEF00D, 6'b010011, 32'h80, 32'hAAAA, 32'hDEADBEEF, 32'hCAFEF00D};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 32'h80, 32'hAAAA, 32'hDEADBEEF, 32'hCAFEF00D};

    for (int i = 0; i < 13; i++) begin
      start = tbl[i].start; if_req = tbl[i].ifr; if_addr = tbl[i].ifa;
      dm_req = tbl[i].dmr; dm_we = tbl[i].dmwe; dm_addr = tbl[i].dma; dm_wdata = tbl[i].dmwd;
      mem_done = tbl[i].done; mem_rdata = tbl[i].rd;
      tick();
      chk($sformatf("vec%0d_ctrl", i), {58'd0, ctrl()}, {58'd0, tbl[i].ectrl});
      chk($sformatf("vec%0d_addr", i), {32'd0, mem_addr}, {32'd0, tbl[i].eaddr});
      chk($sformatf("vec%0d_wdata", i), {32'd0, mem_wdata}, {32'd0, tbl[i].ewdata});
      chk($sformatf("vec%0d_rdata", i), {if_rdata, dm_rdata}, {tbl[i].eifrd, tbl[i].edmrd});
    end

    // ---------------- contention: DM x4 then IF ----------------
    do_reset();
    start = 1; if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    for (int c = 0; c < 200 && gseq.size() < 10; c++) begin
      tick();
      if (if_ack) gseq.push_back(2'd0);
      if (dm_ack) gseq.push_back(2'd1);
      mem_done = mem_en;
      mem_rdata = $urandom;
    end
    mem_done = 0;
    chk("contend_count", 64'(gseq.size()), 64'd10);
    for (int k = 0; k < gseq.size(); k++) begin
      exp_g = (k % 5 == 4) ? 0 : 1;
      chk($sformatf("contend_grant%0d", k), {62'd0, gseq[k]}, 64'(exp_g));
    end

    // ---------------- start_i gating ----------------
    do_reset();
    start = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    tick();
    chk("gate_grant_dm", {58'd0, ctrl()}, {58'd0, 6'b001011});
    start = 0; if_req = 1; if_addr = 32'h310;
    tick();
    mem_done = 1; mem_rdata = 32'h77;
    tick();
    chk("gate_dm_ack", {58'd0, ctrl()}, {58'd0, 6'b010011});
    chk("gate_dm_rdata", {32'd0, dm_rdata}, 64'h77);
    mem_done = 0; dm_req = 0;
    tick();
    for (int w = 0; w < 3; w++) begin
      tick();
      chk($sformatf("gate_hold%0d", w), {58'd0, ctrl()}, {58'd0, 6'b000001});
    end
    start = 1;
    tick();
    chk("gate_if_grant", {58'd0, ctrl()}, {58'd0, 6'b001010});
    chk("gate_if_addr", {32'd0, mem_addr}, 64'h310);
    mem_done = 1; mem_rdata = 32'h1357;
    tick();
    chk("gate_if_ack", {58'd0, ctrl()}, {58'd0, 6'b100010});
    if_req = 0; mem_done = 0;
    tick();

    // ---------------- async reset mid-BUSY ----------------
    start = 1; dm_req = 1; dm_we = 1; dm_addr = 32'h500; dm_wdata = 32'h99;
    tick();
    chk("rst_pre_busy", {58'd0, ctrl()}, {58'd0, 6'b001111});
    #3;
    rst = 1;
    #1;
    chk("rst_async_ctrl", {58'd0, ctrl()}, 64'd0);
    chk("rst_async_addr", {mem_addr, mem_wdata}, 64'd0);
    rst = 0; dm_req = 0;
    tick();
    chk("rst_idle_after", {58'd0, ctrl()}, 64'd0);
    dm_req = 1;
    tick();
    chk("rst_regrant", {58'd0, ctrl()}, {58'd0, 6'b001111});
    mem_done = 1;
    tick();
    chk("rst_regrant_ack", {58'd0, ctrl()}, {58'd0, 6'b010011});
    mem_done = 0; dm_req = 0;
    tick();

    // ---------------- random traffic vs reference model ----------------
    do_reset();
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      model_cycle();
      if (if_ack) begin
        if_req = 1'($urandom % 2); if_addr = $urandom;
      end else if (!if_req && ($urandom % 4 == 0)) begin
        if_req = 1; if_addr = $urandom;
      end
      if (dm_ack) begin
        dm_req = 1'($urandom % 2); dm_we = 1'($urandom % 2); dm_addr = $urandom; dm_wdata = $urandom;
      end else if (!dm_req && ($urandom % 3 == 0)) begin
        dm_req = 1; dm_we = 1'($urandom % 2); dm_addr = $urandom; dm_wdata = $urandom;
      end
      start = ($urandom % 8 != 0);
      mem_done = mem_en ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
      mem_rdata = $urandom;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
